// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word fetches to instruction memory, holds one
// instruction for decode, and handles redirects that arrive while a fetch is in flight.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        andi,
    output logic        ori,
    output logic        xori
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] discard_addr, discard_addr_nx;
    logic        load;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx        = state;
        pc_nx           = pc;
        discard_addr_nx = discard_addr;
        load            = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) pc_nx = redirect_pc;
                state_nx = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_nx = redirect_pc;
                    // An un-acked request must still be drained before the new address goes out.
                    if (!imem_ack) begin
                        discard_addr_nx = pc;
                        state_nx        = DISCARD;
                    end
                end else if (imem_ack) begin
                    load     = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    state_nx = FETCH;
                end else if (id_ready) begin
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) pc_nx = redirect_pc;
                if (imem_ack) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            discard_addr <= '0;
            instr        <= '0;
            pc_out       <= '0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            discard_addr <= discard_addr_nx;
            if (load) begin
                instr  <= imem_rdata;
                pc_out <= pc;
            end
        end
    end

    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = (state == DISCARD) ? discard_addr : pc;
    assign id_valid  = (state == HOLD);

    assign imm16 = instr[15:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign andi  = (instr[31:26] == 6'b001100);
    assign ori   = (instr[31:26] == 6'b001101);
    assign xori  = (instr[31:26] == 6'b001110);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table for streaming fetches plus
// hand-written sequences for stalls, redirects, discard, wrap-around and reset abort.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] pc_out, instr;
    logic [15:0] imm16;
    logic [4:0]  rs, rt, rd;
    logic        andi, ori, xori;

    int passed = 0;
    int total  = 0;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
        .pc_out(pc_out), .instr(instr), .imm16(imm16), .rs(rs), .rt(rt), .rd(rd),
        .andi(andi), .ori(ori), .xori(xori)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcout;
        logic [2:0]  e_sel;   // {andi, ori, xori}
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic e_req, input logic e_valid,
                               input logic [31:0] e_instr, input logic [31:0] e_pcout);
        check({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
        check({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, e_valid});
        check({tag, " instr"}, instr, e_instr);
        check({tag, " pc_out"}, pc_out, e_pcout);
    endtask

    initial begin
        // ack and ready tied high: streaming fetch of ori, andi, xori words.
        vecs[0] = '{1'b0, 32'h0, 1'b1, 32'h3421_8000, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          3'b000};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 32'h3421_8000, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,          32'h0,          3'b000};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h30A5_FFFF, 1'b1, 1'b0, 32'h0,          1'b1, 32'h3421_8000, 32'h0040_0000, 3'b010};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h30A5_FFFF, 1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h3421_8000, 32'h0040_0000, 3'b010};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h38E6_1234, 1'b1, 1'b0, 32'h0,          1'b1, 32'h30A5_FFFF, 32'h0040_0004, 3'b100};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h38E6_1234, 1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h30A5_FFFF, 32'h0040_0004, 3'b100};
        vecs[6] = '{1'b0, 32'h0, 1'b1, 32'h38E6_1234, 1'b0, 1'b0, 32'h0,          1'b1, 32'h38E6_1234, 32'h0040_0008, 3'b001};

        // Reset values.
        step();
        step();
        check_state("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        check("reset imem_addr", imem_addr, 32'h0040_0000);
        check("reset decode", {imm16, 1'b0, rs, rt, rd, andi, ori, xori},
              {16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000});
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            id_ready    = vecs[i].ready;
            check_state($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid,
                        vecs[i].e_instr, vecs[i].e_pcout);
            if (vecs[i].e_req) check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d sel", i), {29'b0, andi, ori, xori}, {29'b0, vecs[i].e_sel});
            step();
        end

        // Stall in HOLD for five cycles: everything frozen.
        for (int i = 0; i < 5; i++) begin
            check_state($sformatf("stall%0d", i), 1'b0, 1'b1, 32'h38E6_1234, 32'h0040_0008);
            step();
        end
        check("xori imm16", {16'h0, imm16}, 32'h0000_1234);
        check("xori rs/rt/rd", {17'b0, rs, rt, rd}, {17'b0, 5'd7, 5'd6, 5'd2});
        check("xori sel", {29'b0, andi, ori, xori}, 32'h1);
        id_ready = 1'b1;
        step();

        // Redirect while un-acked: DISCARD holds old address for three cycles.
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0100;
        check("redir fetch addr", imem_addr, 32'h0040_000C);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
            check_state($sformatf("discard%0d", i), 1'b1, 1'b0, 32'h38E6_1234, 32'h0040_0008);
            check($sformatf("discard%0d addr", i), imem_addr, 32'h0040_000C);
            step();
        end
        check_state("after discard", 1'b1, 1'b0, 32'h38E6_1234, 32'h0040_0008);
        check("after discard addr", imem_addr, 32'h0040_0100);

        // Redirect coincident with ack: data dropped, stay in FETCH at new pc.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; imem_rdata = 32'h0000_0020;
        check_state("redir+ack", 1'b1, 1'b0, 32'h38E6_1234, 32'h0040_0008);
        check("redir+ack addr", imem_addr, 32'hFFFF_FFFC);

        // Wrap-around of pc.
        step();
        check_state("wrap hold", 1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFC);
        check("wrap sel", {29'b0, andi, ori, xori}, 32'h0);
        step();
        check("wrap next addr", imem_addr, 32'h0000_0000);

        // Redirect in HOLD beats id_ready.
        imem_rdata = 32'h1111_1111;
        step();
        redirect = 1'b1; redirect_pc = 32'h0040_0200;
        check_state("hold pre-redir", 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0000);
        step();
        check_state("hold redir", 1'b1, 1'b0, 32'h1111_1111, 32'h0000_0000);
        check("hold redir addr", imem_addr, 32'h0040_0200);

        // Redirects inside DISCARD; the one in the ack cycle wins.
        imem_ack = 1'b0; redirect_pc = 32'h0040_0300;
        step();
        redirect_pc = 32'h0040_0400;
        step();
        check("discard redir addr", imem_addr, 32'h0040_0200);
        check("discard redir req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1; redirect_pc = 32'h0040_0500;
        step();
        check("discard ack redir addr", imem_addr, 32'h0040_0500);
        check("discard ack redir valid", {31'b0, id_valid}, 32'h0);

        // Reset during DISCARD aborts the request at once.
        imem_ack = 1'b0; redirect_pc = 32'h0040_0600;
        step();
        redirect = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_state("rst in discard", 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst in discard addr", imem_addr, 32'h0040_0000);
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        rst = 1'b0;
        step();
        check_state("post-rst fetch", 1'b1, 1'b0, 32'h0, 32'h0);
        check("post-rst addr", imem_addr, 32'h0040_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port redirect  input  1  one-cycle pulse; load fetch PC from redirect_pc.
REQ-005 SHALL have port redirect_pc  input  32  new fetch address, word-aligned.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  output  32  request address.
REQ-008 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port id_valid  output  1  held instruction is valid for the decode stage.
REQ-011 SHALL have port id_ready  input  1  decode stage consumes the held instruction.
REQ-012 SHALL have ports pc_out (output, 32) and instr (output, 32), giving the held instruction and its address.
REQ-013 SHALL have ports imm16 (output, 16), rs/rt/rd (output, 5 each), giving instr[15:0], [25:21], [20:16], [15:11].
REQ-014 SHALL have ports andi, ori, xori (output, 1 each), the zero-extension selects for the immediate extender.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HOLD, DISCARD; registers pc (next fetch address), instr, pc_out.
REQ-016 SHALL drive imem_req=1 exactly in FETCH and DISCARD; imem_addr SHALL equal pc in FETCH and the latched in-flight address in DISCARD, stable while imem_req=1.
REQ-017 SHALL move IDLE->FETCH unconditionally one cycle after reset release.
REQ-018 In FETCH with imem_ack=1 and redirect=0: SHALL latch instr<=imem_rdata, pc_out<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), go to HOLD.
REQ-019 In FETCH with imem_ack=0: SHALL stay in FETCH, imem_addr unchanged.
REQ-020 id_valid SHALL be 1 exactly in HOLD.
REQ-021 In HOLD with id_ready=1 and redirect=0: SHALL go to FETCH; instr/pc_out hold their values.
REQ-022 In HOLD with id_ready=0: SHALL hold every output stable.
REQ-023 Redirect in IDLE or HOLD: SHALL load pc<=redirect_pc and go to FETCH; redirect SHALL take priority over id_ready, so the held instruction is dropped.
REQ-024 Redirect in FETCH with imem_ack=1 in the same cycle: SHALL discard imem_rdata, load pc<=redirect_pc, and stay in FETCH.
REQ-025 Redirect in FETCH with imem_ack=0: SHALL latch the in-flight address, load pc<=redirect_pc, and go to DISCARD.
REQ-026 DISCARD SHALL hold imem_req=1 on the old address until imem_ack, drop the data, then go to FETCH.
REQ-027 A further redirect in DISCARD SHALL overwrite pc; a redirect in the ack cycle SHALL win.
REQ-028 Decode outputs SHALL be combinational from instr.
REQ-029 andi SHALL be 1 iff instr[31:26]=6'b001100; ori iff 6'b001101; xori iff 6'b001110.

Reset
REQ-030 While rst=1: state=IDLE, pc=RESET_PC, instr=0, pc_out=0, id_valid=0, imem_req=0; decode outputs SHALL all be 0.
REQ-031 rst asserted in any state, including DISCARD, SHALL abort the in-flight request immediately; no instruction SHALL be delivered from a pre-reset request.

Verification
REQ-032 Reset release, imem_ack tied 1, id_ready tied 1 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on successive FETCH cycles; id_valid toggles 0/1.
REQ-033 Fetch returns 0x3421_8000 (ori) -> in HOLD: instr=0x34218000, imm16=0x8000, rs=1, rt=1, ori=1, andi=0, xori=0.
REQ-034 id_ready=0 for 5 cycles in HOLD -> id_valid, instr, pc_out constant; imem_req=0 throughout.
REQ-035 Redirect to 0x00400100 in FETCH, ack 3 cycles later -> DISCARD with old address held, data dropped, next imem_addr=0x00400100.
REQ-036 Redirect coincident with imem_ack in FETCH -> no HOLD entry, id_valid stays 0, next imem_addr=redirect_pc.
REQ-037 pc=0xFFFF_FFFC acked -> pc_out=0xFFFFFFFC, next imem_addr=0x00000000.
